// File: rtl/apb_master_ctrl.sv
// APB master bridge: turns one request/response command into an APB transfer
// to one of SLAVES_NUM address-decoded completers, with stall timeout.
module apb_master_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SLAVES_NUM     = 4,
  parameter int unsigned REGION_SHIFT   = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned STROBE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic                             req_write,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [STROBE_WIDTH-1:0]          req_strb,
  input  logic [2:0]                       req_prot,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [SLAVES_NUM-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STROBE_WIDTH-1:0]          PSTRB,
  output logic [2:0]                       PPROT,
  input  logic [SLAVES_NUM-1:0]            PREADY,
  input  logic [SLAVES_NUM-1:0]            PSLVERR,
  input  logic [SLAVES_NUM*DATA_WIDTH-1:0] PRDATA
);

  localparam int unsigned IDX_W = (SLAVES_NUM > 1) ? $clog2(SLAVES_NUM) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, req_idx;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0]   addr_shifted;
  logic                    req_hit;
  logic [SLAVES_NUM-1:0]   psel_dec;
  logic [DATA_WIDTH-1:0]   wdata_masked;
  logic                    sel_ready, sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  logic                    req_ready_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d, pwdata_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [SLAVES_NUM-1:0]   psel_d;
  logic                    penable_d, pwrite_d;
  logic [STROBE_WIDTH-1:0] pstrb_d;
  logic [2:0]              pprot_d;

  // Region decode of the incoming request and byte-strobe masking of its data
  always_comb begin
    addr_shifted = req_addr >> REGION_SHIFT;
    req_hit      = addr_shifted < ADDR_WIDTH'(SLAVES_NUM);
    req_idx      = IDX_W'(addr_shifted);
    psel_dec     = SLAVES_NUM'(1) << req_idx;
    for (int k = 0; k < int'(STROBE_WIDTH); k++) begin
      wdata_masked[k*8 +: 8] = req_strb[k] ? req_wdata[k*8 +: 8] : 8'h00;
    end
  end

  // Completion signals of the currently selected slave only
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(SLAVES_NUM); i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next state and next values of every registered output
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    paddr_d       = PADDR;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    pwdata_d      = PWDATA;
    pstrb_d       = PSTRB;
    pprot_d       = PPROT;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          if (req_hit) begin
            state_d   = SETUP;
            idx_d     = req_idx;
            cnt_d     = '0;
            paddr_d   = req_addr;
            pwrite_d  = req_write;
            pprot_d   = req_prot;
            pstrb_d   = req_write ? req_strb : '0;
            pwdata_d  = req_write ? wdata_masked : '0;
            psel_d    = psel_dec;
            penable_d = 1'b0;
          end else begin
            // Unmapped address: answer directly without touching the bus
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (sel_ready) begin
          state_d       = RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = sel_err;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = PWRITE ? '0 : sel_rdata;
        end else if (TO_EN && (cnt_inc == TO_LIMIT)) begin
          state_d       = RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          cnt_d         = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PADDR       <= '0;
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      PADDR       <= paddr_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
      PPROT       <= pprot_d;
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed scenarios plus random transactions
// checked cycle by cycle against a transaction-level expectation.
module tb_apb_master_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NS = 4;
  localparam int unsigned SW = DW / 8;
  localparam int          TO = 16;

  logic           PCLK;
  logic           PRESET;
  logic           req_valid, req_ready, req_write;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  req_wdata;
  logic [SW-1:0]  req_strb;
  logic [2:0]     req_prot;
  logic           rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0]  rsp_rdata;
  logic [AW-1:0]  PADDR;
  logic [NS-1:0]  PSEL, PREADY, PSLVERR;
  logic           PENABLE, PWRITE;
  logic [DW-1:0]  PWDATA;
  logic [SW-1:0]  PSTRB;
  logic [2:0]     PPROT;
  logic [NS*DW-1:0] PRDATA;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLAVES_NUM(NS),
    .REGION_SHIFT(12), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] strobe_mask(input logic [DW-1:0] d, input logic [SW-1:0] s);
    return d & {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic scramble_slaves(input int keep_idx, input logic [DW-1:0] keep_data);
    PREADY  = NS'($urandom);
    PSLVERR = NS'($urandom);
    for (int i = 0; i < int'(NS); i++) PRDATA[i*DW +: DW] = $urandom;
    if (keep_idx >= 0) begin
      PREADY[keep_idx]            = 1'b0;
      PRDATA[keep_idx*DW +: DW]   = keep_data;
    end
  endtask

  task automatic wait_req_ready();
    int t = 0;
    while (req_ready !== 1'b1 && t < 20) begin
      @(negedge PCLK);
      t++;
    end
    check_eq("req_ready_idle", 64'(req_ready), 64'(1));
  endtask

  // One complete transfer: request, APB phases, response hold, release
  task automatic do_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input logic [2:0] pr, input int waits,
                        input logic slverr, input logic [DW-1:0] slice,
                        input int rsp_delay, input logic hold_req);
    int            idx;
    bit            hit, tout;
    logic [NS-1:0] exp_psel;
    logic [DW-1:0] exp_rd, exp_wd;
    logic          exp_err;

    idx  = int'(addr >> 12);
    hit  = idx < int'(NS);
    tout = 1'b0;
    exp_wd = wr ? strobe_mask(wd, st) : '0;
    wait_req_ready();
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd;
    req_strb = st; req_prot = pr; rsp_ready = 1'b0;
    scramble_slaves(hit ? idx : -1, slice);
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = hold_req; req_addr = $urandom; req_wdata = $urandom;
    req_strb = SW'($urandom); req_write = 1'($urandom);

    if (!hit) begin
      exp_err = 1'b1;
      exp_rd  = '0;
      check_eq("dec_rsp_valid", 64'(rsp_valid), 64'(1));
      check_eq("dec_psel", 64'(PSEL), 64'(0));
      check_eq("dec_err", 64'(rsp_err), 64'(1));
      check_eq("dec_timeout", 64'(rsp_timeout), 64'(0));
      check_eq("dec_rdata", 64'(rsp_rdata), 64'(0));
    end else begin
      exp_psel = NS'(1) << idx;
      check_eq("setup_psel", 64'(PSEL), 64'(exp_psel));
      check_eq("setup_penable", 64'(PENABLE), 64'(0));
      check_eq("setup_paddr", 64'(PADDR), 64'(addr));
      check_eq("setup_pwrite", 64'(PWRITE), 64'(wr));
      check_eq("setup_pwdata", 64'(PWDATA), 64'(exp_wd));
      check_eq("setup_pstrb", 64'(PSTRB), 64'(wr ? st : 4'h0));
      check_eq("setup_pprot", 64'(PPROT), 64'(pr));
      check_eq("setup_req_ready", 64'(req_ready), 64'(0));
      check_eq("setup_rsp_valid", 64'(rsp_valid), 64'(0));
      for (int c = 0; c < TO; c++) begin
        @(posedge PCLK);
        @(negedge PCLK);
        check_eq("access_psel", 64'(PSEL), 64'(exp_psel));
        check_eq("access_penable", 64'(PENABLE), 64'(1));
        check_eq("access_paddr", 64'(PADDR), 64'(addr));
        check_eq("access_pwdata", 64'(PWDATA), 64'(exp_wd));
        check_eq("access_rsp_valid", 64'(rsp_valid), 64'(0));
        scramble_slaves(idx, slice);
        if (c == waits) begin
          PREADY[idx]  = 1'b1;
          PSLVERR[idx] = slverr;
          break;
        end
        if (c == TO - 1) tout = 1'b1;
      end
      @(posedge PCLK);
      @(negedge PCLK);
      scramble_slaves(-1, '0);
      exp_err = tout ? 1'b1 : slverr;
      exp_rd  = (tout || wr) ? '0 : slice;
      check_eq("resp_valid", 64'(rsp_valid), 64'(1));
      check_eq("resp_psel", 64'(PSEL), 64'(0));
      check_eq("resp_penable", 64'(PENABLE), 64'(0));
      check_eq("resp_err", 64'(rsp_err), 64'(exp_err));
      check_eq("resp_timeout", 64'(rsp_timeout), 64'(tout));
      check_eq("resp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    end

    for (int d = 0; d < rsp_delay; d++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      scramble_slaves(-1, '0);
      check_eq("hold_valid", 64'(rsp_valid), 64'(1));
      check_eq("hold_req_ready", 64'(req_ready), 64'(0));
      check_eq("hold_psel", 64'(PSEL), 64'(0));
      check_eq("hold_err", 64'(rsp_err), 64'(exp_err));
      check_eq("hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
    end

    rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_eq("release_valid", 64'(rsp_valid), 64'(0));
    check_eq("release_req_ready", 64'(req_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
    PREADY = '0; PSLVERR = '0; PRDATA = '0;
    #1 PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    check_eq("rst_req_ready", 64'(req_ready), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_psel", 64'(PSEL), 64'(0));
    check_eq("rst_penable", 64'(PENABLE), 64'(0));
    check_eq("rst_paddr", 64'(PADDR), 64'(0));
    check_eq("rst_pwdata", 64'(PWDATA), 64'(0));
    check_eq("rst_rdata", 64'(rsp_rdata), 64'(0));
    PRESET = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check_eq("post_rst_req_ready", 64'(req_ready), 64'(1));

    // Write to slave 1 with partial strobes, zero-wait slave
    do_txn(32'h0000_1004, 1'b1, 32'hA5A5_A5A5, 4'b0101, 3'b010, 0, 1'b0, 32'h1234_5678, 0, 1'b0);
    check_eq("t1_pwdata_const", 64'(PWDATA), 64'h00A5_00A5);
    // Read from slave 2 with three wait states
    do_txn(32'h0000_2000, 1'b0, 32'h0, 4'hF, 3'b000, 3, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    // Decode error
    do_txn(32'h0000_5000, 1'b0, 32'h0, 4'hF, 3'b001, 0, 1'b0, 32'h0, 0, 1'b0);
    // Timeout, ready on the limit cycle, slave error
    do_txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, 3'b000, 100, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
    do_txn(32'h0000_3008, 1'b0, 32'h0, 4'hF, 3'b000, TO - 1, 1'b0, 32'h0BAD_CAFE, 0, 1'b0);
    do_txn(32'h0000_1100, 1'b1, 32'h5555_AAAA, 4'hF, 3'b100, 0, 1'b1, 32'h0, 0, 1'b0);
    // Response back-pressure with a competing request pending
    do_txn(32'h0000_2040, 1'b0, 32'h0, 4'hF, 3'b000, 1, 1'b0, 32'h7777_1111, 5, 1'b1);
    do_txn(32'h0000_0004, 1'b1, 32'h0102_0304, 4'b1010, 3'b011, 0, 1'b0, 32'h0, 0, 1'b0);

    // Reset in the middle of an access phase
    wait_req_ready();
    req_valid = 1'b1; req_addr = 32'h0000_3010; req_write = 1'b0; rsp_ready = 1'b0;
    scramble_slaves(3, 32'h0);
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check_eq("pre_rst_penable", 64'(PENABLE), 64'(1));
    #1 PRESET = 1'b1;
    #1;
    check_eq("async_rst_psel", 64'(PSEL), 64'(0));
    check_eq("async_rst_penable", 64'(PENABLE), 64'(0));
    check_eq("async_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("async_rst_req_ready", 64'(req_ready), 64'(0));
    @(negedge PCLK);
    PRESET = 1'b0;
    scramble_slaves(-1, '0);
    @(posedge PCLK);
    @(negedge PCLK);
    check_eq("after_rst_no_rsp", 64'(rsp_valid), 64'(0));
    do_txn(32'h0000_3020, 1'b0, 32'h0, 4'hF, 3'b000, 2, 1'b0, 32'h600D_D00D, 1, 1'b0);

    // Random traffic, including unmapped regions and occasional stalls
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      int w;
      a = {16'h0, 4'($urandom_range(0, 5)), 10'($urandom), 2'b00};
      w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      do_txn(a, 1'($urandom), $urandom, SW'($urandom), 3'($urandom), w, 1'($urandom),
             $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
